// File: rtl/sel_stepper.sv
// sel_stepper: button/auto-scan driven 2-bit path select for the 2-to-4 decoder.
// Buttons are synchronized, debounced and edge-detected; auto-scan steps from a prescaler.

module sel_debounce #(
    parameter int unsigned CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_rise
);

    localparam int unsigned CW = $clog2(CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_level;
    logic          r_level_d;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_s1      <= i_raw;
            r_s2      <= r_s1;
            r_level_d <= r_level;
            if (r_s2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                r_level <= r_s2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Only a 0->1 transition of the accepted level counts as a press.
    assign o_rise = r_level & ~r_level_d;

endmodule

module sel_stepper #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned SCAN_DIV        = 8
) (
    input  logic       clk1,
    input  logic       rst,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       auto_en,
    output logic [1:0] select,
    output logic       step
);

    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);

    logic          w_next_ev;
    logic          w_prev_ev;
    logic [1:0]    r_sel;
    logic [1:0]    w_sel_nx;
    logic          r_step;
    logic          w_step_nx;
    logic [PW-1:0] r_pre;
    logic [PW-1:0] w_pre_nx;

    sel_debounce #(
        .CYCLES(DEBOUNCE_CYCLES)
    ) u_db_next (
        .i_clk (clk1),
        .i_rst (rst),
        .i_raw (btn_next),
        .o_rise(w_next_ev)
    );

    sel_debounce #(
        .CYCLES(DEBOUNCE_CYCLES)
    ) u_db_prev (
        .i_clk (clk1),
        .i_rst (rst),
        .i_raw (btn_prev),
        .o_rise(w_prev_ev)
    );

    // Button events win over auto-scan and restart its interval.
    always_comb begin
        w_sel_nx  = r_sel;
        w_step_nx = 1'b0;
        w_pre_nx  = '0;
        if (w_next_ev && w_prev_ev) begin
            w_pre_nx = '0;
        end else if (w_next_ev) begin
            w_sel_nx  = r_sel + 2'd1;
            w_step_nx = 1'b1;
        end else if (w_prev_ev) begin
            w_sel_nx  = r_sel - 2'd1;
            w_step_nx = 1'b1;
        end else if (auto_en) begin
            if (r_pre == P_LAST) begin
                w_sel_nx  = r_sel + 2'd1;
                w_step_nx = 1'b1;
            end else begin
                w_pre_nx = r_pre + 1'b1;
            end
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_sel  <= 2'b00;
            r_step <= 1'b0;
            r_pre  <= '0;
        end else begin
            r_sel  <= w_sel_nx;
            r_step <= w_step_nx;
            r_pre  <= w_pre_nx;
        end
    end

    assign select = r_sel;
    assign step   = r_step;

endmodule

// File: tb/tb_sel_stepper.sv
// tb_sel_stepper: randomized and directed bench for sel_stepper.
// A window-based behavioural model predicts select/step every cycle.

module tb_sel_stepper;

    localparam int DB = 4;
    localparam int SD = 8;

    logic       clk1 = 1'b0;
    logic       rst = 1'b1;
    logic       btn_next = 1'b0;
    logic       btn_prev = 1'b0;
    logic       auto_en = 1'b0;
    logic [1:0] select;
    logic       step;

    sel_stepper #(
        .DEBOUNCE_CYCLES(DB),
        .SCAN_DIV(SD)
    ) dut (
        .clk1    (clk1),
        .rst     (rst),
        .btn_next(btn_next),
        .btn_prev(btn_prev),
        .auto_en (auto_en),
        .select  (select),
        .step    (step)
    );

    always #5 clk1 = ~clk1;

    int n_chk = 0;
    int n_fail = 0;
    int n_steps = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model state: raw samples per edge, accepted levels, pending press events.
    bit hn[$];
    bit hp[$];
    bit st_n, st_p, pe_n, pe_p, m_step;
    int m_sel, m_phase;

    function automatic void m_reset();
        hn.delete();
        hp.delete();
        for (int i = 0; i < DB + 2; i++) begin
            hn.push_back(1'b0);
            hp.push_back(1'b0);
        end
        st_n = 0; st_p = 0; pe_n = 0; pe_p = 0;
        m_sel = 0; m_phase = 0; m_step = 0;
    endfunction

    // Level flips once the last DB samples seen through the 2-flop delay all differ.
    function automatic bit all_ne(input bit h[$], input bit st);
        for (int i = 0; i < DB; i++)
            if (h[h.size() - 3 - i] == st) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void m_edge(input bit n, input bit p, input bit a);
        m_step = 0;
        if (pe_n && pe_p) begin
            m_phase = 0;
        end else if (pe_n) begin
            m_sel = (m_sel + 1) % 4; m_step = 1; m_phase = 0;
        end else if (pe_p) begin
            m_sel = (m_sel + 3) % 4; m_step = 1; m_phase = 0;
        end else if (a) begin
            if (m_phase == SD - 1) begin
                m_sel = (m_sel + 1) % 4; m_step = 1; m_phase = 0;
            end else begin
                m_phase++;
            end
        end else begin
            m_phase = 0;
        end
        hn.push_back(n);
        hp.push_back(p);
        pe_n = 0;
        pe_p = 0;
        if (all_ne(hn, st_n)) begin st_n = !st_n; pe_n = st_n; end
        if (all_ne(hp, st_p)) begin st_p = !st_p; pe_p = st_p; end
        if (hn.size() > 64) begin
            void'(hn.pop_front());
            void'(hp.pop_front());
        end
    endfunction

    task automatic tick();
        bit sn, sp, sa;
        sn = btn_next; sp = btn_prev; sa = auto_en;
        @(posedge clk1);
        m_edge(sn, sp, sa);
        #1;
        check("select", select, m_sel);
        check("step", step, m_step);
        if (step) n_steps++;
    endtask

    task automatic do_reset();
        #3;
        rst = 1'b1;
        #1;
        check("rst_async_sel", select, 0);
        check("rst_async_step", step, 0);
        repeat (2) begin
            @(posedge clk1);
            #1;
            check("rst_hold_sel", select, 0);
            check("rst_hold_step", step, 0);
        end
        rst = 1'b0;
        m_reset();
    endtask

    task automatic press(input bit nx, input bit pv);
        btn_next = nx; btn_prev = pv;
        repeat (10) tick();
        btn_next = 0; btn_prev = 0;
        repeat (10) tick();
    endtask

    initial begin
        int s0, lat, k;
        int exp_t[8] = '{8, 16, 24, 32, 35, 43, 51, 61};

        repeat (3) @(posedge clk1);
        #1;
        check("init_sel", select, 0);
        check("init_step", step, 0);
        rst = 1'b0;
        m_reset();
        repeat (20) tick();
        check("idle_sel", select, 0);

        // Bounced next press, then bounced release.
        for (int b = 0; b < 5; b++) begin
            btn_next = 1; repeat ($urandom_range(1, 3)) tick();
            btn_next = 0; repeat ($urandom_range(1, 3)) tick();
        end
        s0 = n_steps;
        lat = 0;
        btn_next = 1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (step && lat == 0) lat = i;
        end
        check("db_latency", lat, DB + 3);
        for (int b = 0; b < 5; b++) begin
            btn_next = 0; repeat ($urandom_range(1, 3)) tick();
            btn_next = 1; repeat ($urandom_range(1, 3)) tick();
        end
        btn_next = 0;
        repeat (12) tick();
        check("db_steps", n_steps - s0, 1);
        check("db_sel", select, 1);

        press(1, 0);
        check("pre_rst_sel", select, 2);
        do_reset();
        repeat (20) tick();
        check("post_rst_sel", select, 0);

        for (int w = 0; w < 4; w++) begin
            s0 = n_steps;
            press(1, 0);
            check("wrap_next_sel", select, (w + 1) % 4);
            check("wrap_next_steps", n_steps - s0, 1);
        end
        s0 = n_steps;
        press(0, 1);
        check("wrap_prev_sel", select, 3);
        check("wrap_prev_steps", n_steps - s0, 1);

        s0 = n_steps;
        press(1, 1);
        check("both_sel", select, 3);
        check("both_steps", n_steps - s0, 0);

        do_reset();
        k = 0;
        for (int i = 1; i <= 62; i++) begin
            if (i == 1) auto_en = 1;
            if (i == 29) btn_next = 1;
            if (i == 41) btn_next = 0;
            if (i == 53) auto_en = 0;
            if (i == 54) auto_en = 1;
            tick();
            if (step) begin
                if (k < 8) check("scan_at", i, exp_t[k]);
                check("scan_sel", select, (k + 1) % 4);
                k++;
            end
        end
        check("scan_cnt", k, 8);

        for (int seg = 0; seg < 400; seg++) begin
            int len;
            len = $urandom_range(1, 12);
            btn_next = ($urandom_range(0, 2) == 0);
            btn_prev = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) auto_en = !auto_en;
            for (int j = 0; j < len; j++) tick();
            if (seg == 150 || seg == 300) do_reset();
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/sel_stepper.md
# sel_stepper

Upstream driver for the 2-to-4 path decoder: produces the 2-bit `select` code that the decoder turns into a one-hot path enable. Two push-buttons (next/prev) are synchronized, debounced and edge-detected to step the code up or down with wrap-around. An optional auto-scan mode advances the code from a clock prescaler. The block is fully synchronous to `clk1`, with an asynchronous active-high reset.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive cycles a synchronized button level must differ from its debounced level before that level is accepted. Legal range is ≥1; the hardware build uses 500000.
- `SCAN_DIV`, default 8: clock cycles per auto-scan step. Legal range is ≥2.
- `clk1`, in, 1: single system clock; all state on rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `btn_next`, in, 1: raw, asynchronous, bouncing button; high = pressed.
- `btn_prev`, in, 1: raw, asynchronous, bouncing button; high = pressed.
- `auto_en`, in, 1: synchronous level; 1 enables auto-scan.
- `select`, out, 2: current path code, registered; feeds the decoder's `select`.
- `step`, out, 1: registered one-cycle pulse, high in the first cycle `select` holds a new value.

## Operation
- **Reset** (async assert, released sync to `clk1`):
  - `select`=2'b00, `step`=0.
  - Synchronizer flops, debounced levels, debounce counters and prescaler all cleared to 0.
- **Synchronizer:** per button, two flops (`s1`→`s2`). Nothing downstream samples a raw button.
- **Debounce (per button):**
  - Counter width is clog2(DEBOUNCE_CYCLES)+1.
  - If `s2`==stable, the counter clears to 0.
  - Otherwise the counter increments. When it would reach DEBOUNCE_CYCLES, stable takes `s2` and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles restarts the count and is rejected.
- **Press event:** the cycle the debounced level goes 0→1. Releases (1→0) generate nothing. Holding a button produces exactly one event.
- **Next-state rules**, priority top-down, evaluated every cycle:
  - `next_ev` and `prev_ev` in the same cycle: no change, no `step`, prescaler cleared.
  - `next_ev` only: `select`+1 mod 4 (11→00); `step`=1; prescaler cleared.
  - `prev_ev` only: `select`−1 mod 4 (00→11); `step`=1; prescaler cleared.
  - `auto_en`=1 and prescaler==SCAN_DIV−1: `select`+1 mod 4; `step`=1; prescaler→0.
  - `auto_en`=1 otherwise: prescaler+1; `select` held; `step`=0.
  - `auto_en`=0: prescaler held at 0; `select` held; `step`=0.
- Button events take priority over, and restart, the auto-scan interval.
- `auto_en` dropping mid-interval discards the partial count. Re-enabling starts a full SCAN_DIV interval.
- `select` always holds a legal code; no invalid states exist.

## Timing
- Button latency: raw rising input first sampled at edge N (into `s1`).
  - `s2` updates at N+1.
  - Debounced level rises at N+1+DEBOUNCE_CYCLES.
  - `select`/`step` update at N+2+DEBOUNCE_CYCLES. With default 4, that is 6 edges after the first sample.
- Auto-scan: with `auto_en` high from edge M onward, `select` advances at M+SCAN_DIV−1, then every SCAN_DIV edges.
- `step` is high for exactly one cycle per `select` change and never without a change.
- The minimum spacing between steps is 1 cycle: a button event immediately following an auto tick is honoured.
- Reset asserted mid-debounce or mid-scan: every output reaches its reset value asynchronously, with no `step` pulse. After release, a button still held high must re-satisfy the full synchronizer plus debounce latency before any event.

## Test plan
- **Reset:** assert `rst` mid-cycle with `select`=2'b10 → `select`=00 and `step`=0 immediately, without waiting for a clock edge. Release with all inputs low → no change for 20 cycles.
- **Debounced next:** DEBOUNCE_CYCLES=4. Bounce `btn_next` 1/0 with pulses of 1–3 cycles, then hold high 10 cycles →
  - exactly one `step`;
  - `select` 00→01, 6 edges after the held level starts;
  - release with bounce → no further change.
- **Wrap both directions:** four next presses from 00 → 01,10,11,00. Then one prev press → 11. Each press gives exactly one `step`.
- **Simultaneous presses:** drive `btn_next` and `btn_prev` high on the same edge, held 10 cycles → `select` unchanged, `step` never asserted.
- **Auto-scan:** SCAN_DIV=8, `auto_en`=1 from reset value 00 → `select` 01,10,11,00 on edges 7,15,23,31 after enable, with `step` on each.
- **Auto/button interaction:** during auto-scan, complete a next press 3 cycles into an interval → `select`+1 at that point. The next auto tick comes SCAN_DIV edges later. Dropping `auto_en` for 1 cycle restarts the full interval.
